rename_table_ckpt: RTL and testbench
====================================

# rename_table_ckpt

Register alias table for the out-of-order rename stage, with checkpointing. It keeps a speculative map and a committed map from architectural register IDs to physical tags, plus a ring of NUM_CKPT snapshots of the speculative map. Branch mispredicts restore the map in one cycle from a snapshot, with no commit-side walk. It sits between decode/rename and the ROB/commit logic, and writeback ports snoop it to set availability.

## Interface
Parameters:
- NUM_LOOKUP, 8, source-operand lookup ports; must be a multiple of NUM_ISSUE
- NUM_ISSUE, 4, rename (issue) write ports
- NUM_COMMIT, 4, commit write ports
- NUM_WB, 4, writeback snoop ports
- NUM_REGS, 32, architectural registers; register 0 is hardwired
- ID_SIZE, $clog2(NUM_REGS), register ID width
- TAG_SIZE, 7, physical tag width
- NUM_CKPT, 4, checkpoint ring depth; must be a power of two
- CKPT_ID_SIZE, $clog2(NUM_CKPT), checkpoint index width

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IN_lookupIDs  in  NUM_LOOKUP*ID_SIZE  source registers to look up
- OUT_lookupAvail  out  NUM_LOOKUP  operand ready
- OUT_lookupSpecTag  out  NUM_LOOKUP*TAG_SIZE  current speculative tag
- IN_issueValid / IN_issueIDs / IN_issueTags / IN_issueAvail  in  NUM_ISSUE / *ID_SIZE / *TAG_SIZE / NUM_ISSUE  new destination mappings
- IN_ckptReq  in  1  snapshot the map after this cycle's issue group
- OUT_ckptId  out  CKPT_ID_SIZE  index the snapshot will receive (tail pointer)
- OUT_ckptFull  out  1  ring full; a request is dropped
- IN_ckptFree  in  1  release the oldest checkpoint (branch committed)
- IN_restoreValid / IN_restoreId  in  1 / CKPT_ID_SIZE  restore the speculative map from a checkpoint
- IN_flush  in  1  full flush: spec map <- committed map, ring emptied
- IN_commitValid / IN_commitIDs / IN_commitTags  in  NUM_COMMIT / *ID_SIZE / *TAG_SIZE  retiring mappings
- OUT_commitPrevTags  out  NUM_COMMIT*TAG_SIZE  tag being superseded (to be freed)
- IN_wbValid / IN_wbTag  in  NUM_WB / *TAG_SIZE  result tags written back

## Operation
- **State per register:** spec {avail, tag}, committed tag, and NUM_CKPT snapshots {avail, tag}. Ring state is head, tail and count (0..NUM_CKPT).
- **Reset values:** every tag = 1<<(TAG_SIZE-1), every avail = 1, head = tail = count = 0. Outputs at reset: OUT_ckptFull = 0, OUT_ckptId = 0.
- **Register 0:** never written. A lookup of ID 0 returns avail 1 and the reset tag.
- **Lookup (combinational):**
  - Start from the spec entry.
  - Any wbValid[j] with wbTag equal to the resulting tag forces avail to 1.
  - Lookup i then forwards from issue slots j < i/(NUM_LOOKUP/NUM_ISSUE) whose ID matches and is nonzero. The highest such j wins and supplies issueTag and issueAvail.
- **Issue:** for valid, nonzero ID, write spec {issueAvail, issueTag}. When slots collide on an ID, the higher slot wins.
- **Writeback:** for each valid wbTag, set avail in the spec map and in every live checkpoint entry whose tag matches.
- **Checkpoint:**
  - Accepted when IN_ckptReq=1 and count<NUM_CKPT (pre-edge), with no flush and no restore that cycle.
  - It stores the post-issue, post-writeback spec map into slot tail, then sets tail++ and count++.
  - OUT_ckptFull = (count==NUM_CKPT). A request while full is dropped.
- **Free:** IN_ckptFree with count>0 sets head++ and count--. It is ignored when empty.
- **Restore:**
  - Spec map <- ckpt[restoreId]; writebacks in the same cycle apply to the restored values.
  - tail <- restoreId+1 mod NUM_CKPT, and count is recomputed as (tail−head) mod NUM_CKPT, or NUM_CKPT if restoreId is the last live slot before wrap.
  - Issue in the same cycle is discarded.
  - restoreId must be live. Driving a non-live ID is an assertion failure.
- **Flush:**
  - Spec tag <- committed tag and avail <- 1 for all registers.
  - head = tail = count = 0.
  - Issue, restore and ckptReq in the same cycle are ignored.
- **Priority:** flush > restore > issue/checkpoint. Commit and free always apply.
- **Commit:**
  - For valid, nonzero ID, committed tag <- commitTag.
  - OUT_commitPrevTags[i] is the committed tag before update. It is forwarded from the highest earlier commit slot k<i with the same ID and valid.
  - When a flush coincides with a commit, the flush uses the pre-commit committed map and the commits then apply to both maps.

## Timing
- Lookup, OUT_commitPrevTags, OUT_ckptId and OUT_ckptFull are combinational from current state and inputs.
- All state updates occur on the rising edge and are visible to lookups the next cycle.
- Checkpoint-to-restore: a restore may target a checkpoint the cycle after it is taken.
- Restore latency is 1 cycle: the restored map is visible on the next cycle's lookups.
- A free and a request in the same cycle while full: the request is dropped, since fullness is evaluated pre-edge.
- rst asserted mid-operation overrides all inputs for that edge.

## Test plan
- Reset, then look up r5 -> avail=1, tag=0x40. Look up r0 after issuing r0->0x11 -> still 0x40.
- Issue r3->0x12 avail=0 in slot 0 and look up r3 on lookup port 2 in the same cycle -> tag 0x12, avail 0 (forwarded). Port 0 -> old tag.
- Issue r3->0x12 with ckptReq (id 0), issue r3->0x13, wb 0x12, restore 0 -> next cycle r3 tag 0x12, avail=1.
- Request 5 checkpoints with NUM_CKPT=4 -> 4th request sets full, 5th dropped, OUT_ckptId wraps 3->0. A free then clears full.
- Commit r7->0x20 in slot 0 and r7->0x21 in slot 2 -> prevTags 0x40 and 0x20. Committed r7 = 0x21. A flush the next cycle sets spec r7 = 0x21.
- Flush, restore and issue in the same cycle -> flush result only. count = 0, OUT_ckptId = 0.

Source files
------------

// File: rtl/rename_table_ckpt.sv
// rename_table_ckpt
//   Register alias table for the out-of-order rename stage. It holds a
//   speculative map and a committed map from architectural register IDs to
//   physical tags, plus a ring of NUM_CKPT snapshots of the speculative map.
//   A branch mispredict restores the speculative map from a snapshot in one
//   cycle. Writeback ports snoop the map and the live snapshots to mark tags
//   available.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   IN_lookupIDs        source registers to look up (NUM_LOOKUP ports)
//   OUT_lookupAvail     operand ready per lookup port
//   OUT_lookupSpecTag   current speculative tag per lookup port
//   IN_issue*           new destination mappings from the rename group
//   IN_ckptReq          snapshot the map after this cycle's issue group
//   OUT_ckptId          ring slot the next snapshot will take (tail)
//   OUT_ckptFull        ring full; a request this cycle is dropped
//   IN_ckptFree         release the oldest snapshot
//   IN_restoreValid/Id  restore the speculative map from a live snapshot
//   IN_flush            speculative map <- committed map, ring emptied
//   IN_commit*          retiring mappings into the committed map
//   OUT_commitPrevTags  committed tag superseded by each commit slot
//   IN_wbValid/Tag      result tags written back
module rename_table_ckpt #(
  parameter int NUM_LOOKUP   = 8,
  parameter int NUM_ISSUE    = 4,
  parameter int NUM_COMMIT   = 4,
  parameter int NUM_WB       = 4,
  parameter int NUM_REGS     = 32,
  parameter int ID_SIZE      = $clog2(NUM_REGS),
  parameter int TAG_SIZE     = 7,
  parameter int NUM_CKPT     = 4,
  parameter int CKPT_ID_SIZE = $clog2(NUM_CKPT)
) (
  input  logic                             clk,
  input  logic                             rst,

  input  logic [NUM_LOOKUP*ID_SIZE-1:0]    IN_lookupIDs,
  output logic [NUM_LOOKUP-1:0]            OUT_lookupAvail,
  output logic [NUM_LOOKUP*TAG_SIZE-1:0]   OUT_lookupSpecTag,

  input  logic [NUM_ISSUE-1:0]             IN_issueValid,
  input  logic [NUM_ISSUE*ID_SIZE-1:0]     IN_issueIDs,
  input  logic [NUM_ISSUE*TAG_SIZE-1:0]    IN_issueTags,
  input  logic [NUM_ISSUE-1:0]             IN_issueAvail,

  input  logic                             IN_ckptReq,
  output logic [CKPT_ID_SIZE-1:0]          OUT_ckptId,
  output logic                             OUT_ckptFull,
  input  logic                             IN_ckptFree,

  input  logic                             IN_restoreValid,
  input  logic [CKPT_ID_SIZE-1:0]          IN_restoreId,

  input  logic                             IN_flush,

  input  logic [NUM_COMMIT-1:0]            IN_commitValid,
  input  logic [NUM_COMMIT*ID_SIZE-1:0]    IN_commitIDs,
  input  logic [NUM_COMMIT*TAG_SIZE-1:0]   IN_commitTags,
  output logic [NUM_COMMIT*TAG_SIZE-1:0]   OUT_commitPrevTags,

  input  logic [NUM_WB-1:0]                IN_wbValid,
  input  logic [NUM_WB*TAG_SIZE-1:0]       IN_wbTag
);

  localparam int CNT_W = CKPT_ID_SIZE + 1;
  localparam int LOOKUP_PER_ISSUE = NUM_LOOKUP / NUM_ISSUE;
  localparam logic [TAG_SIZE-1:0] RESET_TAG = TAG_SIZE'(1) << (TAG_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_CKPT);

  // Architectural state
  logic [TAG_SIZE-1:0] spec_tag [NUM_REGS];
  logic [NUM_REGS-1:0] spec_avail;
  logic [TAG_SIZE-1:0] comm_tag [NUM_REGS];
  logic [TAG_SIZE-1:0] ckpt_tag [NUM_CKPT][NUM_REGS];
  logic [NUM_REGS-1:0] ckpt_avail [NUM_CKPT];
  logic [CKPT_ID_SIZE-1:0] head;
  logic [CKPT_ID_SIZE-1:0] tail;
  logic [CNT_W-1:0] count;

  // Next-state values
  logic [TAG_SIZE-1:0] spec_tag_n [NUM_REGS];
  logic [NUM_REGS-1:0] spec_avail_n;
  logic [TAG_SIZE-1:0] comm_tag_n [NUM_REGS];
  logic [NUM_REGS-1:0] ckpt_wb_hit [NUM_CKPT];
  logic [CKPT_ID_SIZE-1:0] head_n;
  logic [CKPT_ID_SIZE-1:0] tail_n;
  logic [CNT_W-1:0] count_n;

  logic [NUM_CKPT-1:0] live;
  logic restore_en;
  logic issue_en;
  logic ckpt_en;
  logic free_en;

  // Operation qualifiers: flush beats restore, restore beats issue/checkpoint.
  // Fullness is judged on the pre-edge count, so a free in the same cycle
  // does not make room for a request.
  always_comb begin
    restore_en = IN_restoreValid && !IN_flush;
    issue_en   = !IN_flush && !IN_restoreValid;
    ckpt_en    = IN_ckptReq && (count != FULL_CNT) && !IN_flush && !IN_restoreValid;
    free_en    = IN_ckptFree && (count != '0);
  end

  // A slot is live when its distance from head (mod ring size) is below count.
  always_comb begin
    logic [CKPT_ID_SIZE-1:0] off;
    live = '0;
    off  = '0;
    for (int s = 0; s < NUM_CKPT; s++) begin
      off = CKPT_ID_SIZE'(s) - head;
      live[s] = ({1'b0, off} < count);
    end
  end

  assign OUT_ckptId   = tail;
  assign OUT_ckptFull = (count == FULL_CNT);

  // Lookup: spec entry, then same-cycle writeback bypass on the spec tag,
  // then forwarding from earlier issue slots of this rename group. Each issue
  // slot owns LOOKUP_PER_ISSUE lookup ports, so port i may only see slots
  // strictly before its own. Register 0 always reads as ready with the
  // reset tag.
  always_comb begin
    logic [ID_SIZE-1:0]  lid;
    logic [TAG_SIZE-1:0] tag;
    logic                avail;
    OUT_lookupAvail   = '0;
    OUT_lookupSpecTag = '0;
    lid   = '0;
    tag   = '0;
    avail = 1'b0;
    for (int i = 0; i < NUM_LOOKUP; i++) begin
      lid   = IN_lookupIDs[i*ID_SIZE +: ID_SIZE];
      tag   = spec_tag[lid];
      avail = spec_avail[lid];
      for (int j = 0; j < NUM_WB; j++) begin
        if (IN_wbValid[j] && (IN_wbTag[j*TAG_SIZE +: TAG_SIZE] == tag)) begin
          avail = 1'b1;
        end
      end
      for (int j = 0; j < NUM_ISSUE; j++) begin
        if ((j < i / LOOKUP_PER_ISSUE) && IN_issueValid[j] &&
            (IN_issueIDs[j*ID_SIZE +: ID_SIZE] != '0) &&
            (IN_issueIDs[j*ID_SIZE +: ID_SIZE] == lid)) begin
          tag   = IN_issueTags[j*TAG_SIZE +: TAG_SIZE];
          avail = IN_issueAvail[j];
        end
      end
      if (lid == '0) begin
        tag   = RESET_TAG;
        avail = 1'b1;
      end
      OUT_lookupSpecTag[i*TAG_SIZE +: TAG_SIZE] = tag;
      OUT_lookupAvail[i] = avail;
    end
  end

  // Previous committed tag per commit slot, forwarded from the highest
  // earlier valid slot that retires the same register.
  always_comb begin
    logic [ID_SIZE-1:0]  cid;
    logic [TAG_SIZE-1:0] prev;
    OUT_commitPrevTags = '0;
    cid  = '0;
    prev = '0;
    for (int i = 0; i < NUM_COMMIT; i++) begin
      cid  = IN_commitIDs[i*ID_SIZE +: ID_SIZE];
      prev = comm_tag[cid];
      for (int k = 0; k < NUM_COMMIT; k++) begin
        if ((k < i) && IN_commitValid[k] &&
            (IN_commitIDs[k*ID_SIZE +: ID_SIZE] != '0) &&
            (IN_commitIDs[k*ID_SIZE +: ID_SIZE] == cid)) begin
          prev = IN_commitTags[k*TAG_SIZE +: TAG_SIZE];
        end
      end
      OUT_commitPrevTags[i*TAG_SIZE +: TAG_SIZE] = prev;
    end
  end

  // Committed map: higher commit slots override lower ones on the same ID.
  always_comb begin
    comm_tag_n = comm_tag;
    for (int k = 0; k < NUM_COMMIT; k++) begin
      if (IN_commitValid[k] && (IN_commitIDs[k*ID_SIZE +: ID_SIZE] != '0)) begin
        comm_tag_n[IN_commitIDs[k*ID_SIZE +: ID_SIZE]] = IN_commitTags[k*TAG_SIZE +: TAG_SIZE];
      end
    end
  end

  // Speculative map. A flush copies the pre-commit committed map and then
  // lets this cycle's commits land on top, so both maps agree afterwards.
  // Otherwise the base is either the current map or the restored snapshot,
  // issue writes are applied (not on restore), and writebacks are matched
  // against the resulting tags. This post-writeback map is also what a
  // checkpoint captures.
  always_comb begin
    spec_tag_n   = spec_tag;
    spec_avail_n = spec_avail;
    if (IN_flush) begin
      spec_tag_n   = comm_tag;
      spec_avail_n = '1;
      for (int k = 0; k < NUM_COMMIT; k++) begin
        if (IN_commitValid[k] && (IN_commitIDs[k*ID_SIZE +: ID_SIZE] != '0)) begin
          spec_tag_n[IN_commitIDs[k*ID_SIZE +: ID_SIZE]] = IN_commitTags[k*TAG_SIZE +: TAG_SIZE];
        end
      end
    end else begin
      if (restore_en) begin
        spec_tag_n   = ckpt_tag[IN_restoreId];
        spec_avail_n = ckpt_avail[IN_restoreId];
      end
      if (issue_en) begin
        for (int j = 0; j < NUM_ISSUE; j++) begin
          if (IN_issueValid[j] && (IN_issueIDs[j*ID_SIZE +: ID_SIZE] != '0)) begin
            spec_tag_n[IN_issueIDs[j*ID_SIZE +: ID_SIZE]]   = IN_issueTags[j*TAG_SIZE +: TAG_SIZE];
            spec_avail_n[IN_issueIDs[j*ID_SIZE +: ID_SIZE]] = IN_issueAvail[j];
          end
        end
      end
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int j = 0; j < NUM_WB; j++) begin
          if (IN_wbValid[j] && (IN_wbTag[j*TAG_SIZE +: TAG_SIZE] == spec_tag_n[r])) begin
            spec_avail_n[r] = 1'b1;
          end
        end
      end
    end
    spec_tag_n[0]   = RESET_TAG;
    spec_avail_n[0] = 1'b1;
  end

  // Writeback hits against every snapshot entry; only live slots use them.
  always_comb begin
    for (int s = 0; s < NUM_CKPT; s++) begin
      ckpt_wb_hit[s] = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int j = 0; j < NUM_WB; j++) begin
          if (IN_wbValid[j] && (IN_wbTag[j*TAG_SIZE +: TAG_SIZE] == ckpt_tag[s][r])) begin
            ckpt_wb_hit[s][r] = 1'b1;
          end
        end
      end
    end
  end

  // Ring pointers. A restore makes restoreId the youngest live slot; when
  // that lands tail back on head the ring is completely full rather than
  // empty, since the restored slot itself is live.
  always_comb begin
    logic [CKPT_ID_SIZE-1:0] raw;
    logic [CNT_W-1:0]        base;
    raw    = '0;
    base   = '0;
    head_n = head + CKPT_ID_SIZE'(free_en);
    if (IN_flush) begin
      head_n  = '0;
      tail_n  = '0;
      count_n = '0;
    end else if (restore_en) begin
      tail_n  = IN_restoreId + CKPT_ID_SIZE'(1);
      raw     = tail_n - head;
      base    = (raw == '0) ? FULL_CNT : {1'b0, raw};
      count_n = base - CNT_W'(free_en);
    end else begin
      tail_n  = tail + CKPT_ID_SIZE'(ckpt_en);
      count_n = count + CNT_W'(ckpt_en) - CNT_W'(free_en);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        spec_tag[r] <= RESET_TAG;
        comm_tag[r] <= RESET_TAG;
        for (int s = 0; s < NUM_CKPT; s++) begin
          ckpt_tag[s][r] <= RESET_TAG;
        end
      end
      spec_avail <= '1;
      for (int s = 0; s < NUM_CKPT; s++) begin
        ckpt_avail[s] <= '1;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      spec_tag   <= spec_tag_n;
      spec_avail <= spec_avail_n;
      comm_tag   <= comm_tag_n;
      for (int s = 0; s < NUM_CKPT; s++) begin
        if (ckpt_en && (tail == CKPT_ID_SIZE'(s))) begin
          ckpt_tag[s]   <= spec_tag_n;
          ckpt_avail[s] <= spec_avail_n;
        end else if (live[s]) begin
          ckpt_avail[s] <= ckpt_avail[s] | ckpt_wb_hit[s];
        end
      end
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
    end
  end

  // A restore must target a live snapshot.
  restore_target_live: assert property (
    @(posedge clk) disable iff (rst) (IN_restoreValid && !IN_flush) |-> live[IN_restoreId]
  );

endmodule

// File: tb/tb_rename_table_ckpt.sv
// tb_rename_table_ckpt
//   Directed bench for rename_table_ckpt. The stimulus process drives one
//   cycle of inputs at a time and queues the hand-computed outputs expected
//   in that cycle; a separate monitor samples the DUT on the falling edge and
//   compares against the queue.
module tb_rename_table_ckpt;

   localparam int NL = 8;
   localparam int NI = 4;
   localparam int NC = 4;
   localparam int NW = 4;
   localparam int IW = 5;
   localparam int TW = 7;
   localparam int CW = 2;

   localparam int K_TAG   = 0;
   localparam int K_AVAIL = 1;
   localparam int K_PREV  = 2;
   localparam int K_CKID  = 3;
   localparam int K_FULL  = 4;

   typedef struct {
      string name;
      int    kind;
      int    idx;
      int    value;
      int    cyc;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [NL*IW-1:0] lookup_ids;
   logic [NL-1:0]    lookup_avail;
   logic [NL*TW-1:0] lookup_spec_tag;
   logic [NI-1:0]    issue_valid;
   logic [NI*IW-1:0] issue_ids;
   logic [NI*TW-1:0] issue_tags;
   logic [NI-1:0]    issue_avail;
   logic             ckpt_req;
   logic [CW-1:0]    ckpt_id;
   logic             ckpt_full;
   logic             ckpt_free;
   logic             restore_valid;
   logic [CW-1:0]    restore_id;
   logic             flush;
   logic [NC-1:0]    commit_valid;
   logic [NC*IW-1:0] commit_ids;
   logic [NC*TW-1:0] commit_tags;
   logic [NC*TW-1:0] commit_prev_tags;
   logic [NW-1:0]    wb_valid;
   logic [NW*TW-1:0] wb_tag;

   exp_t sb[$];
   int   cycle;
   int   vectors;
   int   miscompares;

   rename_table_ckpt dut (
      .clk               (clk),
      .rst               (rst),
      .IN_lookupIDs      (lookup_ids),
      .OUT_lookupAvail   (lookup_avail),
      .OUT_lookupSpecTag (lookup_spec_tag),
      .IN_issueValid     (issue_valid),
      .IN_issueIDs       (issue_ids),
      .IN_issueTags      (issue_tags),
      .IN_issueAvail     (issue_avail),
      .IN_ckptReq        (ckpt_req),
      .OUT_ckptId        (ckpt_id),
      .OUT_ckptFull      (ckpt_full),
      .IN_ckptFree       (ckpt_free),
      .IN_restoreValid   (restore_valid),
      .IN_restoreId      (restore_id),
      .IN_flush          (flush),
      .IN_commitValid    (commit_valid),
      .IN_commitIDs      (commit_ids),
      .IN_commitTags     (commit_tags),
      .OUT_commitPrevTags(commit_prev_tags),
      .IN_wbValid        (wb_valid),
      .IN_wbTag          (wb_tag)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle number used to pair queued expectations with the cycle they belong to.
   always @(posedge clk) cycle <= cycle + 1;

   function automatic int get_actual(int kind, int idx);
      case (kind)
         K_TAG:   return int'(lookup_spec_tag[idx*TW +: TW]);
         K_AVAIL: return int'(lookup_avail[idx]);
         K_PREV:  return int'(commit_prev_tags[idx*TW +: TW]);
         K_CKID:  return int'(ckpt_id);
         default: return int'(ckpt_full);
      endcase
   endfunction

   // Monitor: on each falling edge, compare every expectation queued for the
   // current cycle against what the DUT is presenting.
   exp_t mon_e;
   int   mon_act;
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cycle) begin
         mon_e   = sb.pop_front();
         mon_act = get_actual(mon_e.kind, mon_e.idx);
         vectors++;
         if (mon_act != mon_e.value) begin
            miscompares++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h",
                     mon_e.name, mon_e.cyc, mon_act, mon_e.value);
         end
      end
   end

   task automatic clear_inputs();
      lookup_ids    = '0;
      issue_valid   = '0;
      issue_ids     = '0;
      issue_tags    = '0;
      issue_avail   = '0;
      ckpt_req      = 1'b0;
      ckpt_free     = 1'b0;
      restore_valid = 1'b0;
      restore_id    = '0;
      flush         = 1'b0;
      commit_valid  = '0;
      commit_ids    = '0;
      commit_tags   = '0;
      wb_valid      = '0;
      wb_tag        = '0;
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic checkOutput(input string name, input int kind, input int idx, input int value);
      exp_t e;
      e.name  = name;
      e.kind  = kind;
      e.idx   = idx;
      e.value = value;
      e.cyc   = cycle;
      sb.push_back(e);
   endtask

   task automatic expect_lookup(input string name, input int port, input int tag, input int avail);
      checkOutput({name, ".tag"}, K_TAG, port, tag);
      checkOutput({name, ".avail"}, K_AVAIL, port, avail);
   endtask

   task automatic expect_ring(input string name, input int id, input int full);
      checkOutput({name, ".ckptId"}, K_CKID, 0, id);
      checkOutput({name, ".full"}, K_FULL, 0, full);
   endtask

   task automatic set_lookup(input int port, input int id);
      lookup_ids[port*IW +: IW] = IW'(id);
   endtask

   task automatic set_issue(input int slot, input int id, input int tag, input bit avail);
      issue_valid[slot]          = 1'b1;
      issue_ids[slot*IW +: IW]   = IW'(id);
      issue_tags[slot*TW +: TW]  = TW'(tag);
      issue_avail[slot]          = avail;
   endtask

   task automatic set_commit(input int slot, input bit valid, input int id, input int tag);
      commit_valid[slot]         = valid;
      commit_ids[slot*IW +: IW]  = IW'(id);
      commit_tags[slot*TW +: TW] = TW'(tag);
   endtask

   task automatic set_wb(input int slot, input int tag);
      wb_valid[slot]        = 1'b1;
      wb_tag[slot*TW +: TW] = TW'(tag);
   endtask

   // Watchdog against a hung simulation.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      cycle       = 0;
      vectors     = 0;
      miscompares = 0;
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // C1: reset values; write to r0 is ignored and never forwarded
      applyStimulus();
      rst = 1'b0;
      set_lookup(0, 5);
      set_issue(0, 0, 'h11, 1'b0);
      set_lookup(7, 0);
      expect_lookup("reset_r5", 0, 'h40, 1);
      expect_lookup("r0_fwd", 7, 'h40, 1);
      expect_ring("reset_ring", 0, 0);

      // C2: r0 untouched; forwarding from slot 0 reaches port 2 only; checkpoint 0
      applyStimulus();
      set_lookup(1, 0);
      set_issue(0, 3, 'h12, 1'b0);
      set_lookup(2, 3);
      set_lookup(0, 3);
      ckpt_req = 1'b1;
      expect_lookup("r0_after", 1, 'h40, 1);
      expect_lookup("fwd_port2", 2, 'h12, 0);
      expect_lookup("nofwd_port0", 0, 'h40, 1);
      checkOutput("ckpt0_id", K_CKID, 0, 0);

      // C3: r3 newly mapped; second mapping issued
      applyStimulus();
      set_issue(0, 3, 'h13, 1'b0);
      set_lookup(0, 3);
      expect_lookup("r3_spec", 0, 'h12, 0);
      checkOutput("ckpt_id_after0", K_CKID, 0, 1);

      // C4: restore 0 with writeback of 0x12 in the same cycle
      applyStimulus();
      set_wb(1, 'h12);
      restore_valid = 1'b1;
      restore_id    = 2'd0;
      set_lookup(0, 3);
      expect_lookup("r3_pre_restore", 0, 'h13, 0);

      // C5: restored map with writeback applied
      applyStimulus();
      set_lookup(0, 3);
      expect_lookup("r3_restored", 0, 'h12, 1);
      expect_ring("after_restore", 1, 0);

      // C6: flush empties the ring
      applyStimulus();
      flush = 1'b1;
      checkOutput("pre_flush_id", K_CKID, 0, 1);

      // C7..C10: fill the ring
      applyStimulus();
      set_lookup(0, 3);
      expect_lookup("r3_flushed", 0, 'h40, 1);
      expect_ring("fill0", 0, 0);
      ckpt_req = 1'b1;
      applyStimulus();
      expect_ring("fill1", 1, 0);
      ckpt_req = 1'b1;
      applyStimulus();
      expect_ring("fill2", 2, 0);
      ckpt_req = 1'b1;
      applyStimulus();
      expect_ring("fill3", 3, 0);
      ckpt_req = 1'b1;

      // C11: full, wrapped id; request dropped while a free releases a slot
      applyStimulus();
      expect_ring("full", 0, 1);
      ckpt_req  = 1'b1;
      ckpt_free = 1'b1;

      // C12: room again; snapshot r9 -> 0x25 into slot 0
      applyStimulus();
      expect_ring("after_free", 0, 0);
      ckpt_req = 1'b1;
      set_issue(0, 9, 'h25, 1'b0);

      // C13: full again; restore the youngest slot (0) with a discarded issue
      applyStimulus();
      expect_ring("refull", 1, 1);
      set_lookup(0, 9);
      expect_lookup("r9_spec", 0, 'h25, 0);
      restore_valid = 1'b1;
      restore_id    = 2'd0;
      set_issue(0, 9, 'h26, 1'b1);

      // C14: restoring the last live slot keeps the ring full
      applyStimulus();
      expect_ring("restore_wrap", 1, 1);
      set_lookup(0, 9);
      expect_lookup("r9_issue_dropped", 0, 'h25, 0);

      // C15: writeback bypass on lookup
      applyStimulus();
      set_wb(2, 'h25);
      set_lookup(0, 9);
      expect_lookup("r9_wb_bypass", 0, 'h25, 1);

      // C16: writeback recorded in the map
      applyStimulus();
      set_lookup(0, 9);
      expect_lookup("r9_wb_stored", 0, 'h25, 1);

      // C17: commits with in-group forwarding of the superseded tag
      applyStimulus();
      set_commit(0, 1'b1, 7, 'h20);
      set_commit(1, 1'b1, 8, 'h30);
      set_commit(2, 1'b1, 7, 'h21);
      set_commit(3, 1'b0, 7, 'h7f);
      checkOutput("prev0", K_PREV, 0, 'h40);
      checkOutput("prev1", K_PREV, 1, 'h40);
      checkOutput("prev2", K_PREV, 2, 'h20);
      checkOutput("prev3", K_PREV, 3, 'h21);

      // C18: flush wins over restore, issue and checkpoint; a commit rides along
      applyStimulus();
      flush         = 1'b1;
      restore_valid = 1'b1;
      restore_id    = 2'd2;
      ckpt_req      = 1'b1;
      set_issue(0, 7, 'h55, 1'b0);
      set_commit(0, 1'b1, 8, 'h31);
      checkOutput("prev_flush", K_PREV, 0, 'h30);

      // C19: spec map now mirrors the committed map
      applyStimulus();
      set_lookup(0, 7);
      set_lookup(1, 8);
      set_lookup(2, 9);
      expect_lookup("r7_flushed", 0, 'h21, 1);
      expect_lookup("r8_flushed", 1, 'h31, 1);
      expect_lookup("r9_flushed", 2, 'h40, 1);
      expect_ring("flush_ring", 0, 0);

      // C20: colliding issue slots; port 7 sees slots 0..2, port 2 sees slot 0
      applyStimulus();
      set_issue(1, 4, 'h44, 1'b0);
      set_issue(3, 4, 'h45, 1'b1);
      set_lookup(7, 4);
      set_lookup(6, 4);
      set_lookup(2, 4);
      expect_lookup("collide_p7", 7, 'h44, 0);
      expect_lookup("collide_p6", 6, 'h44, 0);
      expect_lookup("collide_p2", 2, 'h40, 1);

      // C21: higher slot won the write
      applyStimulus();
      set_lookup(0, 4);
      expect_lookup("collide_win", 0, 'h45, 1);
      ckpt_req = 1'b1;

      // C22: reset mid-operation overrides an issue
      applyStimulus();
      checkOutput("pre_rst_id", K_CKID, 0, 1);
      rst = 1'b1;
      set_issue(0, 4, 'h50, 1'b0);

      // C23: everything back to reset values, also checked directly
      applyStimulus();
      rst = 1'b0;
      set_lookup(0, 4);
      set_lookup(1, 7);
      expect_lookup("r4_after_rst", 0, 'h40, 1);
      expect_lookup("r7_after_rst", 1, 'h40, 1);
      expect_ring("ring_after_rst", 0, 0);
      #1;
      vectors++;
      if (lookup_spec_tag[0 +: TW] !== 7'h40) begin
         miscompares++;
         $display("[TB] FAIL direct_r4_tag: got 0x%0h, expected 0x40", lookup_spec_tag[0 +: TW]);
      end
      vectors++;
      if (lookup_avail[0] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL direct_r4_avail: got %0b, expected 1", lookup_avail[0]);
      end
      vectors++;
      if (ckpt_id !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL direct_ckpt_id: got %0d, expected 0", ckpt_id);
      end

      applyStimulus();
      applyStimulus();
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s: never compared, expected 0x%0h", mon_e.name, mon_e.value);
      end

      if (vectors < 12) begin
         miscompares++;
         $display("[TB] FAIL only %0d vectors compared", vectors);
      end
      if (miscompares == 0) begin
         $display("[TB] PASS all checks");
      end else begin
         $display("[TB] FAIL %0d miscompares", miscompares);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
